// File: rtl/wvb_trig_qualifier.sv
// Multi-channel trigger qualifier: fixed-latency edge pipeline with a two-sided
// local-coincidence window, per-channel deadtime and saturating accept/reject counters.
module wvb_trig_qualifier #(
  parameter int unsigned P_N_CH       = 4,
  parameter int unsigned P_LC_MAX     = 31,
  parameter int unsigned P_WIN_WIDTH  = 5,
  parameter int unsigned P_DEAD_WIDTH = 10,
  parameter int unsigned P_CNT_WIDTH  = 32,
  localparam int unsigned SelW        = (P_N_CH > 1) ? $clog2(P_N_CH) : 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic [P_N_CH-1:0]       trig_in,
  input  logic [P_N_CH-1:0]       lc_in,
  input  logic [1:0]              mode,
  input  logic [P_WIN_WIDTH-1:0]  lc_window,
  input  logic [P_DEAD_WIDTH-1:0] dead_len,
  input  logic                    cnt_clr,
  input  logic [SelW-1:0]         cnt_sel,
  output logic [P_N_CH-1:0]       trig_out,
  output logic                    trig_any,
  output logic [P_CNT_WIDTH-1:0]  acc_cnt,
  output logic [P_CNT_WIDTH-1:0]  rej_cnt
);

  typedef enum logic [1:0] {ModePass, ModeLcReq, ModeLcVeto, ModeOff} mode_e;

  localparam int unsigned HistLen = 2 * P_LC_MAX;

  mode_e mode_s;
  assign mode_s = mode_e'(mode);

  logic [P_N_CH-1:0]       trig_prev_q;
  logic [P_N_CH-1:0]       edge_pipe_q [P_LC_MAX];
  logic [P_N_CH-1:0]       edge_pipe_d [P_LC_MAX];
  logic [P_N_CH-1:0]       lc_hist_q   [HistLen];
  logic [P_N_CH-1:0]       lc_hist_d   [HistLen];
  logic [P_N_CH-1:0]       lc_taps     [HistLen+1];
  logic [P_DEAD_WIDTH-1:0] dead_q      [P_N_CH];
  logic [P_DEAD_WIDTH-1:0] dead_d      [P_N_CH];
  logic [P_CNT_WIDTH-1:0]  acc_q       [P_N_CH];
  logic [P_CNT_WIDTH-1:0]  acc_d       [P_N_CH];
  logic [P_CNT_WIDTH-1:0]  rej_q       [P_N_CH];
  logic [P_CNT_WIDTH-1:0]  rej_d       [P_N_CH];
  logic [P_N_CH-1:0]       trig_out_q, trig_out_d;
  logic                    trig_any_q, trig_any_d;
  logic [P_CNT_WIDTH-1:0]  acc_cnt_q, acc_cnt_d;
  logic [P_CNT_WIDTH-1:0]  rej_cnt_q, rej_cnt_d;

  logic [P_N_CH-1:0] edge_new, edge_dec, lc_hit, accept, reject;
  logic [31:0]       win_eff;

  // Edge capture and shift registers for edges and LC history
  always_comb begin
    edge_new = trig_in & ~trig_prev_q & {P_N_CH{en && (mode_s != ModeOff)}};
    edge_pipe_d[0] = edge_new;
    for (int unsigned s = 1; s < P_LC_MAX; s++) begin
      edge_pipe_d[s] = edge_pipe_q[s-1];
    end
    lc_hist_d[0] = lc_in;
    for (int unsigned s = 1; s < HistLen; s++) begin
      lc_hist_d[s] = lc_hist_q[s-1];
    end
    edge_dec = edge_pipe_q[P_LC_MAX-1];
  end

  // Tap k holds lc_in from k cycles before the decision; the edge itself sits at tap P_LC_MAX.
  always_comb begin
    lc_taps[0] = lc_in;
    for (int unsigned k = 1; k <= HistLen; k++) begin
      lc_taps[k] = lc_hist_q[k-1];
    end
    win_eff = 32'(lc_window);
    if (win_eff > P_LC_MAX) begin
      win_eff = P_LC_MAX;
    end
    lc_hit = '0;
    for (int unsigned k = 0; k <= HistLen; k++) begin
      if ((k + win_eff >= P_LC_MAX) && (k <= P_LC_MAX + win_eff)) begin
        lc_hit = lc_hit | lc_taps[k];
      end
    end
  end

  // Decision, deadtime and counters
  always_comb begin
    logic pass;
    logic live;
    logic blocked;
    accept = '0;
    reject = '0;
    for (int unsigned c = 0; c < P_N_CH; c++) begin
      unique case (mode_s)
        ModePass:   pass = 1'b1;
        ModeLcReq:  pass = lc_hit[c];
        ModeLcVeto: pass = !lc_hit[c];
        default:    pass = 1'b0;
      endcase
      live      = edge_dec[c] && (mode_s != ModeOff);
      blocked   = (dead_q[c] != '0);
      accept[c] = live && pass && !blocked;
      reject[c] = live && !(pass && !blocked);

      if (accept[c]) begin
        dead_d[c] = dead_len;
      end else if (blocked) begin
        dead_d[c] = dead_q[c] - 1'b1;
      end else begin
        dead_d[c] = '0;
      end

      acc_d[c] = acc_q[c];
      rej_d[c] = rej_q[c];
      if (cnt_clr) begin
        acc_d[c] = '0;
        rej_d[c] = '0;
      end else begin
        if (accept[c] && (acc_q[c] != '1)) acc_d[c] = acc_q[c] + 1'b1;
        if (reject[c] && (rej_q[c] != '1)) rej_d[c] = rej_q[c] + 1'b1;
      end
    end
    trig_out_d = accept;
    trig_any_d = |accept;

    acc_cnt_d = '0;
    rej_cnt_d = '0;
    for (int unsigned c = 0; c < P_N_CH; c++) begin
      if (cnt_sel == SelW'(c)) begin
        acc_cnt_d = acc_q[c];
        rej_cnt_d = rej_q[c];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      trig_prev_q <= '0;
      for (int unsigned s = 0; s < P_LC_MAX; s++) edge_pipe_q[s] <= '0;
      for (int unsigned s = 0; s < HistLen; s++) lc_hist_q[s] <= '0;
      for (int unsigned c = 0; c < P_N_CH; c++) begin
        dead_q[c] <= '0;
        acc_q[c]  <= '0;
        rej_q[c]  <= '0;
      end
      trig_out_q <= '0;
      trig_any_q <= 1'b0;
      acc_cnt_q  <= '0;
      rej_cnt_q  <= '0;
    end else begin
      trig_prev_q <= trig_in;
      for (int unsigned s = 0; s < P_LC_MAX; s++) edge_pipe_q[s] <= edge_pipe_d[s];
      for (int unsigned s = 0; s < HistLen; s++) lc_hist_q[s] <= lc_hist_d[s];
      for (int unsigned c = 0; c < P_N_CH; c++) begin
        dead_q[c] <= dead_d[c];
        acc_q[c]  <= acc_d[c];
        rej_q[c]  <= rej_d[c];
      end
      trig_out_q <= trig_out_d;
      trig_any_q <= trig_any_d;
      acc_cnt_q  <= acc_cnt_d;
      rej_cnt_q  <= rej_cnt_d;
    end
  end

  assign trig_out = trig_out_q;
  assign trig_any = trig_any_q;
  assign acc_cnt  = acc_cnt_q;
  assign rej_cnt  = rej_cnt_q;

endmodule

// File: tb/tb_wvb_trig_qualifier.sv
// Directed bench for wvb_trig_qualifier: vector table for LC modes plus hand-written
// deadtime, enable, counter and reset sequences. A 4-bit-counter instance checks saturation.
module tb_wvb_trig_qualifier;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b1;
  logic [3:0]  trig_in = '0;
  logic [3:0]  lc_in = '0;
  logic [1:0]  mode = 2'd0;
  logic [4:0]  lc_window = '0;
  logic [9:0]  dead_len = '0;
  logic        cnt_clr = 1'b0;
  logic [1:0]  cnt_sel = '0;
  logic [3:0]  trig_out, trig_out_s;
  logic        trig_any, trig_any_s;
  logic [31:0] acc_cnt, rej_cnt;
  logic [3:0]  acc_cnt_s, rej_cnt_s;

  wvb_trig_qualifier dut (
    .clk(clk), .rst_n(rst_n), .en(en), .trig_in(trig_in), .lc_in(lc_in), .mode(mode),
    .lc_window(lc_window), .dead_len(dead_len), .cnt_clr(cnt_clr), .cnt_sel(cnt_sel),
    .trig_out(trig_out), .trig_any(trig_any), .acc_cnt(acc_cnt), .rej_cnt(rej_cnt)
  );

  wvb_trig_qualifier #(.P_CNT_WIDTH(4)) dut_s (
    .clk(clk), .rst_n(rst_n), .en(en), .trig_in(trig_in), .lc_in(lc_in), .mode(mode),
    .lc_window(lc_window), .dead_len(dead_len), .cnt_clr(cnt_clr), .cnt_sel(cnt_sel),
    .trig_out(trig_out_s), .trig_any(trig_any_s), .acc_cnt(acc_cnt_s), .rej_cnt(rej_cnt_s)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;
  int exp_acc[4];
  int exp_rej[4];

  // Pulse log, sampled mid-cycle
  int pcnt[4];
  int pfirst[4];
  int plast[4];
  int anycnt;
  int anyfirst;

  always @(negedge clk) begin
    for (int c = 0; c < 4; c++) begin
      if (trig_out[c]) begin
        pcnt[c]++;
        if (pfirst[c] < 0) pfirst[c] = cyc;
        plast[c] = cyc;
      end
    end
    if (trig_any) begin
      anycnt++;
      if (anyfirst < 0) anyfirst = cyc;
    end
  end

  task automatic clear_log();
    for (int c = 0; c < 4; c++) begin
      pcnt[c] = 0;
      pfirst[c] = -1;
      plast[c] = -1;
    end
    anycnt = 0;
    anyfirst = -1;
  endtask

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", nm, cyc, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic goto(input int t);
    while (cyc < t) step(1);
  endtask

  task automatic chk_counts(input int ch);
    cnt_sel = 2'(ch);
    step(2);
    chk($sformatf("acc_cnt ch%0d", ch), acc_cnt, exp_acc[ch]);
    chk($sformatf("rej_cnt ch%0d", ch), rej_cnt, exp_rej[ch]);
  endtask

  task automatic clear_model();
    for (int c = 0; c < 4; c++) begin
      exp_acc[c] = 0;
      exp_rej[c] = 0;
    end
  endtask

  typedef struct {
    logic [1:0] mode;
    logic [4:0] win;
    int         ch;
    bit         has_lc;
    int         lc_off;
    int         lc_ch;
    bit         acc;
    bit         rej;
  } vec_t;

  localparam int NV = 13;
  vec_t vecs[NV];

  initial begin
    int base;
    vec_t v;

    vecs[0]  = '{2'd0, 5'd0,  0, 1'b0,   0, 0, 1'b1, 1'b0};  // pass
    vecs[1]  = '{2'd1, 5'd4,  1, 1'b1,   4, 1, 1'b1, 1'b0};  // LC at +w
    vecs[2]  = '{2'd1, 5'd4,  1, 1'b1,   5, 1, 1'b0, 1'b1};  // LC just outside
    vecs[3]  = '{2'd1, 5'd4,  1, 1'b1,  -4, 1, 1'b1, 1'b0};  // LC at -w
    vecs[4]  = '{2'd2, 5'd2,  2, 1'b1,  -2, 2, 1'b0, 1'b1};  // veto hit
    vecs[5]  = '{2'd2, 5'd2,  2, 1'b1,  -3, 2, 1'b1, 1'b0};  // veto miss
    vecs[6]  = '{2'd1, 5'd0,  3, 1'b1,   0, 3, 1'b1, 1'b0};  // w=0 same cycle
    vecs[7]  = '{2'd1, 5'd0,  3, 1'b1,   1, 3, 1'b0, 1'b1};  // w=0 next cycle
    vecs[8]  = '{2'd1, 5'd31, 0, 1'b1,  31, 0, 1'b1, 1'b0};  // full window, late edge
    vecs[9]  = '{2'd1, 5'd31, 0, 1'b1, -31, 0, 1'b1, 1'b0};  // full window, early edge
    vecs[10] = '{2'd1, 5'd31, 2, 1'b1, -32, 2, 1'b0, 1'b1};  // beyond max window
    vecs[11] = '{2'd1, 5'd4,  1, 1'b1,   0, 0, 1'b0, 1'b1};  // LC on other channel
    vecs[12] = '{2'd3, 5'd0,  0, 1'b0,   0, 0, 1'b0, 1'b0};  // disabled: dropped

    clear_model();
    clear_log();
    step(3);
    rst_n = 1'b1;
    step(1);
    chk("reset trig_out", trig_out, 0);
    chk("reset trig_any", trig_any, 0);
    chk("reset acc_cnt", acc_cnt, 0);
    chk("reset rej_cnt", rej_cnt, 0);

    // Table-driven LC-mode vectors
    for (int i = 0; i < NV; i++) begin
      v = vecs[i];
      mode = v.mode;
      lc_window = v.win;
      dead_len = '0;
      base = cyc + 40;
      clear_log();
      for (int t = base - 35; t <= base + 40; t++) begin
        goto(t);
        trig_in = (t == base) ? (4'b0001 << v.ch) : 4'b0000;
        lc_in = (v.has_lc && t == base + v.lc_off) ? (4'b0001 << v.lc_ch) : 4'b0000;
      end
      trig_in = '0;
      lc_in = '0;
      if (v.acc) exp_acc[v.ch]++;
      if (v.rej) exp_rej[v.ch]++;
      chk($sformatf("vec%0d pulse count", i), pcnt[v.ch], v.acc ? 1 : 0);
      chk($sformatf("vec%0d trig_any count", i), anycnt, v.acc ? 1 : 0);
      if (v.acc) begin
        chk($sformatf("vec%0d pulse cycle", i), pfirst[v.ch], base + 32);
        chk($sformatf("vec%0d trig_any cycle", i), anyfirst, base + 32);
      end
      chk_counts(v.ch);
    end

    // Deadtime: accept blocks D+1..D+10; rejects do not extend it
    mode = 2'd0;
    dead_len = 10'd10;
    base = cyc + 5;
    clear_log();
    for (int t = base; t <= base + 60; t++) begin
      goto(t);
      trig_in = (t == base || t == base + 5 || t == base + 10 || t == base + 12) ? 4'b1000
                                                                                 : 4'b0000;
    end
    trig_in = '0;
    exp_acc[3] += 2;
    exp_rej[3] += 2;
    chk("dead pulse count", pcnt[3], 2);
    chk("dead first pulse", pfirst[3], base + 32);
    chk("dead last pulse", plast[3], base + 44);
    chk_counts(3);

    // Deadtime expiry boundary on ch2, ch1 unaffected by ch2's deadtime
    base = cyc + 5;
    clear_log();
    for (int t = base; t <= base + 60; t++) begin
      goto(t);
      trig_in = '0;
      if (t == base || t == base + 11) trig_in[2] = 1'b1;
      if (t == base + 1) trig_in[1] = 1'b1;
    end
    trig_in = '0;
    exp_acc[2] += 2;
    exp_acc[1] += 1;
    chk("dead expiry count", pcnt[2], 2);
    chk("dead expiry last", plast[2], base + 43);
    chk("indep ch1 pulse", pfirst[1], base + 33);
    chk_counts(2);
    dead_len = '0;

    // All channels in the same cycle
    base = cyc + 5;
    clear_log();
    goto(base);
    trig_in = 4'b1111;
    goto(base + 1);
    trig_in = 4'b0000;
    goto(base + 32);
    chk("simul trig_out", trig_out, 4'b1111);
    chk("simul trig_any", trig_any, 1);
    goto(base + 40);
    chk("simul any count", anycnt, 1);
    for (int c = 0; c < 4; c++) exp_acc[c]++;
    chk_counts(0);

    // en falls with an edge in flight; edges while en=0 are dropped
    base = cyc + 5;
    clear_log();
    goto(base);
    trig_in = 4'b0001;
    goto(base + 1);
    trig_in = 4'b0000;
    goto(base + 5);
    en = 1'b0;
    goto(base + 6);
    trig_in = 4'b0010;
    goto(base + 7);
    trig_in = 4'b0000;
    goto(base + 50);
    en = 1'b1;
    exp_acc[0]++;
    chk("en in-flight count", pcnt[0], 1);
    chk("en in-flight cycle", pfirst[0], base + 32);
    chk("en low dropped", pcnt[1], 0);
    chk_counts(1);

    // Counter clear, then saturation on the 4-bit instance
    cnt_clr = 1'b1;
    step(1);
    cnt_clr = 1'b0;
    clear_model();
    base = cyc + 5;
    clear_log();
    for (int i = 0; i < 20; i++) begin
      goto(base + 2 * i);
      trig_in = 4'b0001;
      goto(base + 2 * i + 1);
      trig_in = 4'b0000;
    end
    goto(base + 80);
    exp_acc[0] = 20;
    chk("sat pulse count", pcnt[0], 20);
    chk_counts(0);
    chk("sat acc_cnt small", acc_cnt_s, 15);
    chk("sat rej_cnt small", rej_cnt_s, 0);

    // Clear coincident with an accept: clear wins
    base = cyc + 5;
    goto(base);
    trig_in = 4'b0001;
    goto(base + 1);
    trig_in = 4'b0000;
    goto(base + 31);
    cnt_clr = 1'b1;
    goto(base + 32);
    cnt_clr = 1'b0;
    chk("clr pulse still out", trig_out[0], 1);
    goto(base + 33);
    chk("clr acc_cnt", acc_cnt, 0);
    chk("clr acc_cnt small", acc_cnt_s, 0);
    chk("clr rej_cnt", rej_cnt, 0);
    clear_model();

    // Reset mid-flight; trig_in held high across release gives one edge
    cnt_sel = 2'd0;
    base = cyc + 5;
    clear_log();
    goto(base);
    trig_in = 4'b0001;
    goto(base + 1);
    trig_in = 4'b0000;
    goto(base + 10);
    rst_n = 1'b0;
    goto(base + 11);
    trig_in = 4'b0010;
    goto(base + 13);
    rst_n = 1'b1;
    clear_model();
    chk("rst acc_cnt", acc_cnt, 0);
    chk("rst rej_cnt", rej_cnt, 0);
    chk("rst acc_cnt small", acc_cnt_s, 0);
    goto(base + 90);
    trig_in = 4'b0000;
    chk("rst flushed ch0", pcnt[0], 0);
    chk("rst release edge count", pcnt[1], 1);
    chk("rst release edge cycle", pfirst[1], base + 45);
    exp_acc[1] = 1;
    chk_counts(0);
    chk_counts(1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
